com_cmd_bridge: RTL and testbench

COM_CMD_BRIDGE -- requirements
Module: com_cmd_bridge

---
 rtl/com_pkg.sv | 29 ++
 rtl/com_timeout.sv | 31 +++
 rtl/com_cmd_bridge.sv | 168 ++++++++++++++++
 tb/tb_com_cmd_bridge.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/com_pkg.sv
// Shared types and command codes for the byte-command to memory bridge.
// Define COM_BURST_EN to add the LEN state and the "B" burst-read command.
package com_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
`ifdef COM_BURST_EN
    LEN     = 3'd2,
`endif
    DATA    = 3'd3,
    REQ     = 3'd4,
    WAIT_RD = 3'd5,
    TX      = 3'd6
  } com_state_e;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_BURST = 8'h42;

  function automatic logic cmd_known(input logic [7:0] b);
`ifdef COM_BURST_EN
    return (b == CMD_WRITE) || (b == CMD_READ) || (b == CMD_BURST);
`else
    return (b == CMD_WRITE) || (b == CMD_READ);
`endif
  endfunction

endpackage

// File: rtl/com_timeout.sv
// Inter-byte watchdog: fires once TIMEOUT_CYCLES idle cycles elapse while active.
// A kick in the expiry cycle wins; TIMEOUT_CYCLES = 0 disables the watchdog.
module com_timeout #(
  parameter int TIMEOUT_CYCLES = 27000
) (
  input  logic clk,
  input  logic sys_resetn,
  input  logic active,
  input  logic kick,
  output logic expired
);

  if (TIMEOUT_CYCLES > 0) begin : g_cnt
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (!sys_resetn || kick || !active) cnt_q <= '0;
      else if (cnt_q != LAST)             cnt_q <= cnt_q + CW'(1);
    end

    assign expired = active && !kick && (cnt_q == LAST);
  end else begin : g_off
    logic unused_tie;
    assign unused_tie = ^{clk, sys_resetn, active, kick};
    assign expired    = 1'b0;
  end

endmodule

// File: rtl/com_cmd_bridge.sv
// Byte-stream command parser driving a single-beat memory port and returning read data.
// Define COM_BURST_EN to enable "B" burst reads (LEN state, N+1 sequential words).
module com_cmd_bridge #(
  parameter int ADDR_BYTES     = 2,
  parameter int DATA_BYTES     = 1,
  parameter int TIMEOUT_CYCLES = 27000
) (
  input  logic                    clk,
  input  logic                    sys_resetn,
  input  logic [7:0]              i_com_data,
  input  logic                    i_com_strobe,
  output logic [7:0]              o_com_data,
  output logic                    o_com_strobe,
  input  logic                    i_com_ready,
  output logic [8*ADDR_BYTES-1:0] o_mem_addr,
  output logic [8*DATA_BYTES-1:0] o_mem_wdata,
  output logic                    o_mem_write,
  output logic                    o_mem_valid,
  input  logic                    i_mem_ready,
  input  logic [8*DATA_BYTES-1:0] i_mem_rdata,
  input  logic                    i_mem_rvalid,
  output logic                    o_busy,
  output logic                    o_error
);
  import com_pkg::*;

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;

  com_state_e    state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, tx_q;
  logic [3:0]    bcnt_q;
  logic          wr_q, err_q, err_d;
  logic          active, expired, last_addr, last_data, more_words, rd_done;
`ifdef COM_BURST_EN
  logic          burst_q;
  logic [7:0]    rem_q;
  assign more_words = burst_q && (rem_q != 8'd0);
`else
  assign more_words = 1'b0;
`endif

  assign last_addr = (bcnt_q == 4'(ADDR_BYTES - 1));
  assign last_data = (bcnt_q == 4'(DATA_BYTES - 1));
  // Read data landing together with acceptance skips WAIT_RD entirely.
  assign rd_done   = i_mem_rvalid && !wr_q &&
                     ((state_q == WAIT_RD) || ((state_q == REQ) && i_mem_ready));

`ifdef COM_BURST_EN
  assign active = (state_q == ADDR) || (state_q == LEN) || (state_q == DATA);
`else
  assign active = (state_q == ADDR) || (state_q == DATA);
`endif

  com_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk        (clk),
    .sys_resetn (sys_resetn),
    .active     (active),
    .kick       (i_com_strobe),
    .expired    (expired)
  );

  always_ff @(posedge clk) begin
    if (!sys_resetn) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_com_strobe && cmd_known(i_com_data)) state_d = ADDR;
      ADDR: begin
        if (i_com_strobe && last_addr) begin
`ifdef COM_BURST_EN
          if (burst_q) state_d = LEN; else
`endif
          if (wr_q) state_d = DATA;
          else      state_d = REQ;
        end else if (expired) state_d = IDLE;
      end
`ifdef COM_BURST_EN
      LEN: begin
        if (i_com_strobe) state_d = REQ;
        else if (expired) state_d = IDLE;
      end
`endif
      DATA: begin
        if (i_com_strobe && last_data) state_d = REQ;
        else if (expired)              state_d = IDLE;
      end
      REQ:     if (i_mem_ready) state_d = wr_q ? IDLE : (rd_done ? TX : WAIT_RD);
      WAIT_RD: if (rd_done) state_d = TX;
      TX:      if (i_com_ready && last_data) state_d = more_words ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_busy       = (state_q != IDLE);
    o_mem_valid  = (state_q == REQ);
    o_com_strobe = (state_q == TX) && i_com_ready;
    o_com_data   = tx_q[DW-1 -: 8];
    o_mem_addr   = addr_q;
    o_mem_wdata  = wdata_q;
    o_mem_write  = wr_q;
    o_error      = err_q;
    err_d        = expired ||
                   (i_com_strobe && (state_q == IDLE) && !cmd_known(i_com_data)) ||
                   (i_com_strobe && ((state_q == REQ) || (state_q == WAIT_RD) || (state_q == TX)));
  end

  always_ff @(posedge clk) begin
    if (!sys_resetn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      tx_q    <= '0;
      bcnt_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef COM_BURST_EN
      burst_q <= 1'b0;
      rem_q   <= '0;
`endif
    end else begin
      err_q <= err_d;
      case (state_q)
        IDLE: begin
          bcnt_q <= '0;
          if (i_com_strobe) begin
            wr_q    <= (i_com_data == CMD_WRITE);
`ifdef COM_BURST_EN
            burst_q <= (i_com_data == CMD_BURST);
`endif
          end
        end
        ADDR: if (i_com_strobe) begin
          addr_q <= (addr_q << 8) | AW'(i_com_data);
          bcnt_q <= last_addr ? 4'd0 : bcnt_q + 4'd1;
        end
`ifdef COM_BURST_EN
        LEN: if (i_com_strobe) rem_q <= i_com_data;
`endif
        DATA: if (i_com_strobe) begin
          wdata_q <= (wdata_q << 8) | DW'(i_com_data);
          bcnt_q  <= last_data ? 4'd0 : bcnt_q + 4'd1;
        end
        REQ, WAIT_RD: if (rd_done) tx_q <= i_mem_rdata;
        TX: if (i_com_ready) begin
          tx_q <= tx_q << 8;
          if (last_data) begin
            bcnt_q <= '0;
            if (more_words) begin
              addr_q <= addr_q + AW'(1);
`ifdef COM_BURST_EN
              rem_q  <= rem_q - 8'd1;
`endif
            end
          end else begin
            bcnt_q <= bcnt_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_com_cmd_bridge.sv
// Directed bench for com_cmd_bridge (ADDR_BYTES=2, DATA_BYTES=1, TIMEOUT_CYCLES=100).
// Burst scenario runs when COM_BURST_EN is defined; otherwise "B" must be rejected.
module tb_com_cmd_bridge;

  logic        clk = 1'b0;
  logic        sys_resetn;
  logic [7:0]  i_com_data;
  logic        i_com_strobe;
  logic [7:0]  o_com_data;
  logic        o_com_strobe;
  logic        i_com_ready;
  logic [15:0] o_mem_addr;
  logic [7:0]  o_mem_wdata;
  logic        o_mem_write;
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic [7:0]  i_mem_rdata;
  logic        i_mem_rvalid;
  logic        o_busy;
  logic        o_error;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          err_pulses = 0;
  logic [7:0]  rx_q[$];
  bit          toggle_en = 1'b0;

  always #5 clk = ~clk;

  com_cmd_bridge #(
    .ADDR_BYTES(2), .DATA_BYTES(1), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .sys_resetn(sys_resetn),
    .i_com_data(i_com_data), .i_com_strobe(i_com_strobe),
    .o_com_data(o_com_data), .o_com_strobe(o_com_strobe), .i_com_ready(i_com_ready),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_write(o_mem_write),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata),
    .i_mem_rvalid(i_mem_rvalid), .o_busy(o_busy), .o_error(o_error)
  );

  always @(negedge clk) begin
    if (o_com_strobe) rx_q.push_back(o_com_data);
    if (o_error)      err_pulses++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    i_com_data   = b;
    i_com_strobe = 1'b1;
    @(posedge clk); #1;
    i_com_strobe = 1'b0;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a); send_byte(b); send_byte(c);
  endtask

  task automatic wait_valid(input string tag, output bit ok);
    for (int i = 0; i < 80 && !o_mem_valid; i++) tick(1);
    ok = o_mem_valid;
    check({tag, "_vld"}, o_mem_valid, 1);
  endtask

  task automatic check_rx(input string tag, input int idx, input logic [7:0] exp);
    logic [7:0] b;
    b = (idx < rx_q.size()) ? rx_q[idx] : 8'h00;
    check(tag, b, exp);
  endtask

  // Memory side: verify the request, accept it, and optionally return read data dly cycles later.
  task automatic mem_accept(input string tag, input logic [15:0] addr, input logic wr,
                            input logic [7:0] wd, input int dly, input logic [7:0] rd);
    bit ok;
    wait_valid(tag, ok);
    if (!ok) return;
    check({tag, "_addr"}, o_mem_addr, addr);
    check({tag, "_wr"}, o_mem_write, wr);
    if (wr) check({tag, "_wdata"}, o_mem_wdata, wd);
    i_mem_ready = 1'b1;
    if (!wr && dly == 0) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = rd;
    end
    tick(1);
    i_mem_ready  = 1'b0;
    i_mem_rvalid = 1'b0;
    if (!wr && dly > 0) begin
      tick(dly - 1);
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = rd;
      tick(1);
      i_mem_rvalid = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  o_busy, 0);
    check({tag, "_vld"},   o_mem_valid, 0);
    check({tag, "_stb"},   o_com_strobe, 0);
    check({tag, "_err"},   o_error, 0);
    check({tag, "_wr"},    o_mem_write, 0);
    check({tag, "_addr"},  o_mem_addr, 0);
    check({tag, "_wdata"}, o_mem_wdata, 0);
    check({tag, "_cdata"}, o_com_data, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int base;
    bit ok;

    sys_resetn   = 1'b0;
    i_com_data   = 8'h00;
    i_com_strobe = 1'b0;
    i_com_ready  = 1'b1;
    i_mem_ready  = 1'b0;
    i_mem_rdata  = 8'h00;
    i_mem_rvalid = 1'b0;
    tick(3);
    check_all_zero("rst");
    sys_resetn = 1'b1;
    tick(2);

    // Plain write
    send3(8'h57, 8'h00, 8'h04);
    send_byte(8'h42);
    mem_accept("wr1", 16'h0004, 1'b1, 8'h42, 0, 8'h00);
    check("wr1_idle", o_busy, 0);

    // Read with a dropped strobe during REQ, data 3 cycles after acceptance
    base = rx_q.size();
    send3(8'h52, 8'h00, 8'h04);
    wait_valid("rd1_pre", ok);
    e0 = err_pulses;
    send_byte(8'h77);
    tick(2);
    check("drop_err", 64'(err_pulses - e0), 1);
    check("drop_hold", o_mem_valid, 1);
    mem_accept("rd1", 16'h0004, 1'b0, 8'h00, 3, 8'hA5);
    tick(5);
    check("rd1_cnt", 64'(rx_q.size() - base), 1);
    check_rx("rd1_byte", base, 8'hA5);
    check("rd1_idle", o_busy, 0);

    // Unknown command, then a normal write
    e0 = err_pulses;
    send_byte(8'h58);
    tick(3);
    check("unk_err", 64'(err_pulses - e0), 1);
    check("unk_idle", o_busy, 0);
    send3(8'h57, 8'h00, 8'h01);
    send_byte(8'h11);
    mem_accept("wr2", 16'h0001, 1'b1, 8'h11, 0, 8'h00);

    // Read data arriving with acceptance
    base = rx_q.size();
    send3(8'h52, 8'h00, 8'h05);
    mem_accept("rd2", 16'h0005, 1'b0, 8'h00, 0, 8'h5A);
    tick(4);
    check("rd2_cnt", 64'(rx_q.size() - base), 1);
    check_rx("rd2_byte", base, 8'h5A);

    // Timeout expiry exactly 100 cycles after the last accepted byte
    e0 = err_pulses;
    send_byte(8'h57);
    send_byte(8'h00);
    tick(99);
    check("to_busy99", o_busy, 1);
    check("to_noerr99", 64'(err_pulses - e0), 0);
    tick(1);
    check("to_err100", o_error, 1);
    check("to_idle100", o_busy, 0);
    tick(2);
    check("to_errcnt", 64'(err_pulses - e0), 1);

    // A byte in the expiry cycle wins over the timeout
    e0 = err_pulses;
    send_byte(8'h57);
    send_byte(8'h00);
    repeat (98) @(posedge clk);
    send_byte(8'h33);
    check("to_race_busy", o_busy, 1);
    send_byte(8'h44);
    mem_accept("to_race_wr", 16'h0033, 1'b1, 8'h44, 0, 8'h00);
    check("to_race_err", 64'(err_pulses - e0), 0);

`ifdef COM_BURST_EN
    // Burst read across a byte-carry boundary with a throttled transmitter
    base = rx_q.size();
    toggle_en = 1'b1;
    fork
      begin
        while (toggle_en) begin
          @(posedge clk); #1;
          i_com_ready = ~i_com_ready;
        end
        i_com_ready = 1'b1;
      end
    join_none
    send3(8'h42, 8'h00, 8'hFF);
    send_byte(8'h03);
    mem_accept("bst0", 16'h00FF, 1'b0, 8'h00, 1, 8'h10);
    mem_accept("bst1", 16'h0100, 1'b0, 8'h00, 1, 8'h11);
    mem_accept("bst2", 16'h0101, 1'b0, 8'h00, 1, 8'h12);
    mem_accept("bst3", 16'h0102, 1'b0, 8'h00, 1, 8'h13);
    tick(10);
    toggle_en = 1'b0;
    tick(3);
    check("bst_cnt", 64'(rx_q.size() - base), 4);
    check_rx("bst_b0", base,     8'h10);
    check_rx("bst_b1", base + 1, 8'h11);
    check_rx("bst_b2", base + 2, 8'h12);
    check_rx("bst_b3", base + 3, 8'h13);
    check("bst_idle", o_busy, 0);
`else
    e0 = err_pulses;
    send_byte(8'h42);
    tick(3);
    check("nob_err", 64'(err_pulses - e0), 1);
    check("nob_idle", o_busy, 0);
`endif

    // Reset while waiting for read data; a stale rvalid must be ignored
    send3(8'h52, 8'h00, 8'h08);
    wait_valid("rstw", ok);
    i_mem_ready = 1'b1;
    tick(1);
    i_mem_ready = 1'b0;
    check("rstw_wait", o_busy, 1);
    sys_resetn = 1'b0;
    tick(1);
    sys_resetn = 1'b1;
    check_all_zero("rstw");
    base = rx_q.size();
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 8'hEE;
    tick(1);
    i_mem_rvalid = 1'b0;
    tick(4);
    check("stale_cnt", 64'(rx_q.size() - base), 0);
    check("stale_idle", o_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
